// File: rtl/shift_reg_ctl.sv
// shift_reg_ctl: multi-mode datapath register for the shift-add sequential
// multiplier. One command per cycle (load, serial shifts, clear, fused
// add-and-shift-right), plus a saturating shift counter with a done flag.
//
// Interface contract: there is no valid/ready handshake. When en is high,
// the command on mode is executed on that rising edge unconditionally.
// When en is low, nothing changes. Commands may be issued every cycle.
module shift_reg_ctl #(
  parameter int N  = 10,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  di,
  input  logic          sin,
  input  logic [N-1:0]  addend,
  output logic [N-1:0]  dout,
  output logic          sout,
  output logic [CW-1:0] shift_cnt,
  output logic          done
);

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_SHR    = 3'b010;
  localparam logic [2:0] MODE_SHL    = 3'b011;
  localparam logic [2:0] MODE_CLR    = 3'b100;
  localparam logic [2:0] MODE_ADDSHR = 3'b101;

  // Counter ceiling: after N shifts a full multiply step sequence is complete.
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [N-1:0]  dout_q, dout_d;
  logic          sout_q, sout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    sum;
  logic [CW-1:0] cnt_inc;

  // Unsigned (N+1)-bit sum so the carry survives as the new MSB after the
  // shift; the counter increment stops at the ceiling.
  always_comb begin
    sum     = {1'b0, dout_q} + {1'b0, addend};
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  // Next-state selection; holds by default (covers en low, HOLD, reserved).
  always_comb begin
    dout_d = dout_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          dout_d = di;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        MODE_SHR: begin
          dout_d = {sin, dout_q[N-1:1]};
          sout_d = dout_q[0];
          cnt_d  = cnt_inc;
        end
        MODE_SHL: begin
          dout_d = {dout_q[N-2:0], sin};
          sout_d = dout_q[N-1];
          cnt_d  = cnt_inc;
        end
        MODE_CLR: begin
          dout_d = '0;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        MODE_ADDSHR: begin
          dout_d = sum[N:1];
          sout_d = sum[0];
          cnt_d  = cnt_inc;
        end
        MODE_HOLD: begin
          dout_d = dout_q;
        end
        default: begin
          dout_d = dout_q;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs come straight from registers; done decodes the counter only.
  always_comb begin
    dout      = dout_q;
    sout      = sout_q;
    shift_cnt = cnt_q;
    done      = (cnt_q == CNT_MAX);
  end

endmodule

// File: tb/tb_shift_reg_ctl.sv
// tb_shift_reg_ctl: directed vectors with hand-computed expectations for
// shift_reg_ctl at N=4.
module tb_shift_reg_ctl;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] M_HOLD   = 3'b000;
  localparam logic [2:0] M_LOAD   = 3'b001;
  localparam logic [2:0] M_SHR    = 3'b010;
  localparam logic [2:0] M_SHL    = 3'b011;
  localparam logic [2:0] M_CLR    = 3'b100;
  localparam logic [2:0] M_ADDSHR = 3'b101;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [N-1:0]  di;
  logic          sin;
  logic [N-1:0]  addend;
  logic [N-1:0]  dout;
  logic          sout;
  logic [CW-1:0] shift_cnt;
  logic          done;

  int tests_run;
  int failures;

  logic [N-1:0] collected;
  logic [N-1:0] multiplier;

  shift_reg_ctl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .di        (di),
    .sin       (sin),
    .addend    (addend),
    .dout      (dout),
    .sout      (sout),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] e_dout,
                           input logic e_sout, input logic [CW-1:0] e_cnt,
                           input logic e_done);
    check_eq({tag, ".dout"}, 32'(dout), 32'(e_dout));
    check_eq({tag, ".sout"}, 32'(sout), 32'(e_sout));
    check_eq({tag, ".cnt"},  32'(shift_cnt), 32'(e_cnt));
    check_eq({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  // Driver: apply one command at the falling edge, return 1ns after the
  // rising edge that executes it.
  task automatic do_cmd(input logic c_en, input logic [2:0] c_mode,
                        input logic [N-1:0] c_di, input logic c_sin,
                        input logic [N-1:0] c_add);
    @(negedge clk);
    en     = c_en;
    mode   = c_mode;
    di     = c_di;
    sin    = c_sin;
    addend = c_add;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    rst    = 1'b1;
    en     = 1'b0;
    mode   = M_HOLD;
    di     = '0;
    sin    = 1'b0;
    addend = '0;
    collected = '0;
    multiplier = 4'b0101;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset_init", 4'b0000, 1'b0, 3'd0, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // Reset mid-cycle
    do_cmd(1'b1, M_LOAD, 4'b1010, 1'b0, 4'b0000);
    check_all("load_1010", 4'b1010, 1'b0, 3'd0, 1'b0);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("pre_rst_shr", 4'b0101, 1'b0, 3'd1, 1'b0);
    do_cmd(1'b1, M_LOAD, 4'b1010, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(1'b1, M_LOAD, 4'b0110, 1'b0, 4'b0000);
    check_all("post_rst_load", 4'b0110, 1'b0, 3'd0, 1'b0);

    // SHR with saturation
    do_cmd(1'b1, M_LOAD, 4'b1011, 1'b0, 4'b0000);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("shr1", 4'b0101, 1'b1, 3'd1, 1'b0);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("shr2", 4'b0010, 1'b1, 3'd2, 1'b0);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("shr3", 4'b0001, 1'b0, 3'd3, 1'b0);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("shr4", 4'b0000, 1'b1, 3'd4, 1'b1);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b1, 4'b0000);
    check_all("shr5_sat", 4'b1000, 1'b0, 3'd4, 1'b1);

    // SHL and enable gating
    do_cmd(1'b1, M_LOAD, 4'b0011, 1'b0, 4'b0000);
    check_all("load_0011", 4'b0011, 1'b0, 3'd0, 1'b0);
    do_cmd(1'b1, M_SHL, 4'b0000, 1'b1, 4'b0000);
    check_all("shl1", 4'b0111, 1'b0, 3'd1, 1'b0);
    do_cmd(1'b1, M_SHL, 4'b0000, 1'b0, 4'b0000);
    check_all("shl2", 4'b1110, 1'b0, 3'd2, 1'b0);
    do_cmd(1'b1, M_SHL, 4'b0000, 1'b0, 4'b0000);
    check_all("shl3_msb_out", 4'b1100, 1'b1, 3'd3, 1'b0);
    do_cmd(1'b0, M_LOAD, 4'b1111, 1'b1, 4'b1111);
    check_all("en_low_load", 4'b1100, 1'b1, 3'd3, 1'b0);
    do_cmd(1'b0, M_CLR, 4'b1111, 1'b1, 4'b1111);
    check_all("en_low_clr", 4'b1100, 1'b1, 3'd3, 1'b0);

    // ADDSHR without and with carry
    do_cmd(1'b1, M_LOAD, 4'b0101, 1'b0, 4'b0000);
    do_cmd(1'b1, M_ADDSHR, 4'b0000, 1'b0, 4'b0110);
    check_all("addshr_nc", 4'b0101, 1'b1, 3'd1, 1'b0);
    do_cmd(1'b1, M_LOAD, 4'b1100, 1'b0, 4'b0000);
    do_cmd(1'b1, M_ADDSHR, 4'b0000, 1'b1, 4'b0110);
    check_all("addshr_c", 4'b1001, 1'b0, 3'd1, 1'b0);
    do_cmd(1'b1, M_LOAD, 4'b1111, 1'b0, 4'b0000);
    do_cmd(1'b1, M_ADDSHR, 4'b0000, 1'b0, 4'b1111);
    check_all("addshr_max", 4'b1111, 1'b0, 3'd1, 1'b0);

    // Full multiply 5 x 6
    do_cmd(1'b1, M_LOAD, 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < N; i++) begin
      if (multiplier[i])
        do_cmd(1'b1, M_ADDSHR, 4'b0000, 1'b0, 4'b0110);
      else
        do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0110);
      collected[i] = sout;
    end
    check_eq("mul_product", 32'({dout, collected}), 32'd30);
    check_eq("mul_done", 32'(done), 32'd1);
    check_eq("mul_cnt", 32'(shift_cnt), 32'd4);

    do_cmd(1'b1, M_CLR, 4'b1111, 1'b1, 4'b1111);
    check_all("clr", 4'b0000, 1'b0, 3'd0, 1'b0);

    // Reserved modes hold
    do_cmd(1'b1, M_LOAD, 4'b1001, 1'b0, 4'b0000);
    do_cmd(1'b1, M_SHR, 4'b0000, 1'b0, 4'b0000);
    check_all("pre_rsvd", 4'b0100, 1'b1, 3'd1, 1'b0);
    do_cmd(1'b1, 3'b110, 4'b1111, 1'b1, 4'b1111);
    check_all("rsvd_110", 4'b0100, 1'b1, 3'd1, 1'b0);
    do_cmd(1'b1, 3'b111, 4'b1111, 1'b1, 4'b1111);
    check_all("rsvd_111", 4'b0100, 1'b1, 3'd1, 1'b0);
    do_cmd(1'b1, M_HOLD, 4'b1111, 1'b1, 4'b1111);
    check_all("hold", 4'b0100, 1'b1, 3'd1, 1'b0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctl.md
# shift_reg_ctl

Parametrised multi-mode datapath register for the sequential multiplier. It generalises the plain load/hold register with the following operations, each executed under a one-cycle command:

- right and left serial shift;
- synchronous clear;
- a fused add-and-shift-right step, which is the core step of shift-add multiplication.

A saturating shift counter and a `done` flag let the multiplier controller sequence N steps without its own counter.

## Interface
- `N`, 10, data width in bits (N >= 2)
- `CW`, `$clog2(N+1)`, width of the shift counter (derived; do not override)
- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  reset, asynchronous, active-high; clock `clk`
- `en`  input  1  command enable; when low the block holds regardless of `mode`
- `mode`  input  3  operation select (see Operation)
- `di`  input  N  parallel load data
- `sin`  input  1  serial input bit for shift modes
- `addend`  input  N  operand added in add-shift mode
- `dout`  output  N  register contents (registered)
- `sout`  output  1  bit shifted out by the last shift operation (registered)
- `shift_cnt`  output  CW  number of shift operations since the last load or clear, saturating at N
- `done`  output  1  high when `shift_cnt == N` (combinational from `shift_cnt`)

## Operation
- Reset (asynchronous, `rst` high): `dout = 0`, `sout = 0`, `shift_cnt = 0`, `done = 0`. Reset takes effect immediately, including in the middle of a sequence.
- All commands below apply only when `en = 1`. With `en = 0`, all registers hold.
- `mode` 000, HOLD: no change.
- `mode` 001, LOAD: `dout <= di`, `sout <= 0`, `shift_cnt <= 0`.
- `mode` 010, SHR: `dout <= {sin, dout[N-1:1]}`, `sout <= dout[0]`.
- `mode` 011, SHL: `dout <= {dout[N-2:0], sin}`, `sout <= dout[N-1]`.
- `mode` 100, CLR: `dout <= 0`, `sout <= 0`, `shift_cnt <= 0`.
- `mode` 101, ADDSHR (add-and-shift-right):
  - Form the (N+1)-bit sum `{c, s} = {1'b0, dout} + {1'b0, addend}`, unsigned.
  - `dout <= {c, s[N-1:1]}` and `sout <= s[0]`.
  - The carry is never lost: it becomes the new MSB.
- `mode` 110 and 111: reserved; behave as HOLD.
- Shift counter:
  - SHR, SHL and ADDSHR each increment `shift_cnt` by 1, saturating at N.
  - At saturation the data operation still executes; only the counter stops.
  - LOAD and CLR zero the counter. HOLD and reserved modes leave it unchanged.
- `done` equals `(shift_cnt == N)` and drops when the counter is zeroed.

## Timing
- Single-cycle latency: a command sampled on rising edge k is visible on `dout`, `sout` and `shift_cnt` immediately after edge k.
- No handshake. A new command may be issued every cycle, and back-to-back shifts are the normal use.
- `done` rises in the same cycle that `shift_cnt` reaches N, i.e. after the N-th shift edge.
- Reset deassertion: the first edge with `rst` low executes the command present on that edge.
- `addend`, `di` and `sin` are sampled only on the command edge; they are don't-care otherwise.
- No combinational path from inputs to outputs.

## Test plan
All cases use N=4.
- Reset: drive `rst` high mid-cycle with `dout = 1010` → `dout`, `sout`, `shift_cnt` and `done` all 0 before the next edge. After release, LOAD 0110 → `dout = 0110`.
- SHR with saturation: LOAD 1011, then 4×SHR with `sin = 0`:
  - `dout` goes 0101, 0010, 0001, 0000;
  - `sout` goes 1, 1, 0, 1;
  - `shift_cnt` goes 1..4, with `done = 1` after the 4th shift.
  - A 5th SHR with `sin = 1` gives `dout = 1000`, `sout = 0`, `shift_cnt` stays 4.
- SHL and enable gating:
  - LOAD 0011, then SHL with `sin = 1` → `dout = 0111`, `sout = 0`, `shift_cnt = 1`.
  - Then `en = 0` with `mode` LOAD and `di = 1111` → no change.
- ADDSHR without carry: `dout = 0101`, `addend = 0110` (sum 1011) → `dout = 0101`, `sout = 1`.
- ADDSHR with carry: `dout = 1100`, `addend = 0110` (sum 10010) → `dout = 1001`, `sout = 0`.
- Full multiply 5×6:
  - LOAD 0000 and keep the multiplier 0101 externally.
  - Per step, issue ADDSHR with `addend = 0110` when the multiplier bit is 1, otherwise SHR with `sin = 0`. Collect `sout` bits LSB-first.
  - After 4 steps, `{dout, collected}` = 00011110 (30) and `done = 1`.
  - Then CLR → all outputs 0. Reserved modes 110/111 → no change.
